pipe_buf_stage: RTL and testbench

Generic, parametrised pipeline buffer register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers in the RV32I pipeline. It carries one packed stage struct per entry. Transfers use a valid/ready handshake, so back-pressure (stall) propagates per stage. A synchronous flush squashes in-flight instructions on branch, jump or jalr redirect. DEPTH selects a classic single-entry register (DEPTH=1) or an elastic skid/FIFO buffer (DEPTH>=2) that breaks the ready timing path.

---
 rtl/pipe_buf_stage_pkg.sv | 65 ++++++
 rtl/pipe_buf_stage.sv | 110 +++++++++++
 tb/tb_pipe_buf_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_buf_stage_pkg.sv
// Stage payload structs for the RV32I pipeline registers, their widths and
// the all-zero bubble value shared by every pipe_buf_stage instance.
package pipe_buf_stage_pkg;

    // IF/ID: fetched instruction and its address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_reg_t;

    // ID/EX: decoded operands plus the control bundle for EX/MEM/WB.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        jalr;
    } id_ex_reg_t;

    // EX/MEM: ALU result and store data with memory/writeback control.
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } ex_mem_reg_t;

    // MEM/WB: candidate writeback values and destination.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_reg_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_reg_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_reg_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_reg_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_reg_t);

    // Widest stage payload, so one bubble constant covers every stage.
    localparam int unsigned MAX_STAGE_W = ID_EX_W;

    // All-zero payload: every control bit deasserted, i.e. a NOP.
    localparam logic [MAX_STAGE_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_buf_stage.sv
// Parametrised pipeline buffer stage with valid/ready handshake and flush.
// DEPTH=1 is a classic pipeline register with a combinational ready
// pass-through; DEPTH>=2 is an elastic FIFO whose in_ready is a pure
// function of registered occupancy.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   flush     synchronous squash of all entries (priority over push/pop)
//   in_valid  / in_ready  / in_data   upstream handshake and payload
//   out_valid / out_ready / out_data  downstream handshake and payload
//   count     current occupancy
module pipe_buf_stage
    import pipe_buf_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
        $fatal(1, "pipe_buf_stage: DEPTH=%0d outside 1..8", DEPTH);
    end

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_d;
    logic [DATA_W-1:0] head;
    logic              push, pop;

    // Modulo-DEPTH increment; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? head : '0;
    assign count     = count_q;

    // Next pointers/occupancy; flush wins over any push or pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr;
        wr_ptr_d = wr_ptr;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            count_q <= count_d;
            rd_ptr  <= rd_ptr_d;
            wr_ptr  <= wr_ptr_d;
        end
    end

    if (DEPTH == 1) begin : g_single
        logic [DATA_W-1:0] entry;

        // Ready passes through when the slot is being drained this cycle.
        assign in_ready = (count_q == '0) | out_ready;
        assign head     = entry;

        // Payload storage is not reset; out_valid masks it.
        always_ff @(posedge clk) begin
            if (push && !flush) entry <= in_data;
        end
    end else begin : g_multi
        logic [DATA_W-1:0] mem [DEPTH];

        // Registered-only ready: no out_ready -> in_ready timing path.
        assign in_ready = (count_q < FULL_CNT);
        assign head     = mem[rd_ptr];

        // Payload storage is not reset; out_valid masks it.
        always_ff @(posedge clk) begin
            if (push && !flush) mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: DEPTH=1, 2 and 3 instances share one stimulus
// stream and are each compared to an array-based occupancy model.
module tb_pipe_buf_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [0:0]  cnt0;
    logic [1:0]  cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-depth list, element 0 is the oldest entry.
    int          depth_of [3] = '{1, 2, 3};
    int          msize    [3];
    logic [31:0] mbuf     [3][8];

    always #5 clk = ~clk;

    pipe_buf_stage #(.DATA_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .count(cnt0));

    pipe_buf_stage #(.DATA_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(cnt1));

    pipe_buf_stage #(.DATA_W(32), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input int d, input logic ordy);
        if (depth_of[d] == 1) return (msize[d] == 0) || ordy;
        return msize[d] < depth_of[d];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) msize[d] = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_update(input logic v, input logic [31:0] data,
                                input logic ordy, input logic fl);
        for (int d = 0; d < 3; d++) begin
            logic do_push, do_pop;
            do_push = v && model_ready(d, ordy);
            do_pop  = (msize[d] != 0) && ordy;
            if (fl) begin
                msize[d] = 0;
            end else begin
                if (do_pop) begin
                    for (int i = 0; i < 7; i++) mbuf[d][i] = mbuf[d][i+1];
                    msize[d]--;
                end
                if (do_push) begin
                    mbuf[d][msize[d]] = data;
                    msize[d]++;
                end
            end
        end
    endtask

    task automatic check_all(input logic ordy);
        for (int d = 0; d < 3; d++) begin
            logic        a_rdy, a_ov;
            logic [31:0] a_od, a_cnt, e_od;
            case (d)
                0:       begin a_rdy = rdy0; a_ov = ov0; a_od = od0; a_cnt = 32'(cnt0); end
                1:       begin a_rdy = rdy1; a_ov = ov1; a_od = od1; a_cnt = 32'(cnt1); end
                default: begin a_rdy = rdy2; a_ov = ov2; a_od = od2; a_cnt = 32'(cnt2); end
            endcase
            e_od = (msize[d] != 0) ? mbuf[d][0] : 32'h0;
            check_eq($sformatf("D%0d in_ready", depth_of[d]), 32'(a_rdy), 32'(model_ready(d, ordy)));
            check_eq($sformatf("D%0d out_valid", depth_of[d]), 32'(a_ov), 32'(msize[d] != 0));
            check_eq($sformatf("D%0d out_data", depth_of[d]), a_od, e_od);
            check_eq($sformatf("D%0d count", depth_of[d]), a_cnt, 32'(msize[d]));
        end
    endtask

    // Drive one cycle's inputs mid-low-phase, check, then model the edge.
    task automatic step(input logic v, input logic [31:0] data,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all(ordy);
        model_update(v, data, ordy, fl);
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        model_clear();

        // Reset state.
        #12;
        check_all(1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Streaming through DEPTH=1 with out_ready held high.
        step(1'b1, 32'h11, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b0);
        check_eq("D1 stream out_data", od0, 32'h22);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        check_eq("D1 stream last", od0, 32'h33);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall and fill, then drain with 0xC held upstream until accepted.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        check_eq("D2 fill count", 32'(cnt1), 32'd2);
        check_eq("D2 fill in_ready", 32'(rdy1), 32'd0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush priority over a same-cycle push.
        step(1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("D2 post-flush out_data", od1, 32'h0);
        check_eq("D3 post-flush count", 32'(cnt2), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with DEPTH=2 full.
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst D2 out_valid", 32'(ov1), 32'd0);
        check_eq("rst D2 out_data", od1, 32'h0);
        check_eq("rst D2 count", 32'(cnt1), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("post-rst D2 in_ready", 32'(rdy1), 32'd1);

        // DEPTH=1 full with simultaneous push/pop, then empty pop attempt.
        step(1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b1, 32'h88, 1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b1, 1'b0);
        check_eq("D1 push+pop data", od0, 32'h88);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("D1 empty count", 32'(cnt0), 32'd0);
        step(1'b1, 32'h99, 1'b1, 1'b0);
        step(1'b0, 32'h0,  1'b0, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
